icache_fill_responder: RTL and testbench



---
 rtl/icache_fill_responder.sv | 154 +++++++++++++++
 tb/tb_icache_fill_responder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/icache_fill_responder.sv
// Memory-side icache line-fill responder: one-beat request in, WORDS_PER_LINE-beat burst out after LATENCY cycles.
// Ready only when IDLE with no preload write; response path has no backpressure and beats are never gapped.
module icache_fill_responder #(
  parameter int unsigned           MEM_WORDS  = 4096,
  parameter int unsigned           LINE_SIZE  = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           LATENCY    = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         mem_req_valid_i,
  input  logic [ADDR_WIDTH-1:0]        mem_req_addr_i,
  output logic                         mem_req_ready_o,
  output logic                         mem_rsp_valid_o,
  output logic [31:0]                  mem_rsp_data_o,
  output logic                         mem_rsp_err_o,
  input  logic                         load_we_i,
  input  logic [$clog2(MEM_WORDS)-1:0] load_addr_i,
  input  logic [31:0]                  load_data_i,
  output logic                         busy_o,
  output logic [31:0]                  perf_req_count_o
);
  localparam int unsigned WPL    = LINE_SIZE / 4;
  localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
  localparam int unsigned BEAT_W = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int unsigned LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned EW     = ADDR_WIDTH + 1;
  localparam logic [EW-1:0]     BASE_EXT  = {1'b0, BASE_ADDR};
  localparam logic [EW-1:0]     LIMIT_EXT = BASE_EXT + EW'(4 * MEM_WORDS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WPL - 1);

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  line_idx_q;
  logic              err_q;
  logic [LAT_W-1:0]  lat_cnt_q;
  logic [BEAT_W-1:0] beat_cnt_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_data_q;
  logic              rsp_err_q;
  logic [31:0]       perf_q;

  logic [31:0] mem [MEM_WORDS];

  logic [EW-1:0]     acc_base;
  logic [EW-1:0]     acc_off;
  logic              acc_err;
  logic [IDX_W-1:0]  acc_idx;
  logic              accept;
  logic [IDX_W-1:0]  rd_line;
  logic              rd_err;
  logic [BEAT_W-1:0] rd_beat;
  logic [IDX_W-1:0]  rd_idx;
  logic [31:0]       rd_data;

  // Extra top bit keeps the range compare from wrapping near the top of the address space.
  assign acc_base = {1'b0, mem_req_addr_i} & ~EW'(LINE_SIZE - 1);
  assign acc_err  = (acc_base < BASE_EXT) || ((acc_base + EW'(LINE_SIZE)) > LIMIT_EXT);
  assign acc_off  = acc_base - BASE_EXT;
  assign acc_idx  = IDX_W'(acc_off >> 2);

  assign mem_req_ready_o = rst_ni && (state_q == IDLE) && !load_we_i;
  assign accept          = mem_req_valid_i && mem_req_ready_o;

  // Select the word that the next registered beat will carry.
  always_comb begin
    rd_line = line_idx_q;
    rd_err  = err_q;
    rd_beat = beat_cnt_q + BEAT_W'(1);
    if (state_q != BURST) begin
      rd_beat = '0;
      if (state_q == IDLE) begin
        rd_line = acc_idx;
        rd_err  = acc_err;
      end
    end
  end

  assign rd_idx  = rd_line + IDX_W'(rd_beat);
  assign rd_data = rd_err ? 32'd0 : mem[rd_idx];

  // Array is not reset; the read above sees the pre-write value on a same-edge collision.
  always_ff @(posedge clk_i) begin
    if (load_we_i) begin
      mem[load_addr_i] <= load_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      line_idx_q  <= '0;
      err_q       <= 1'b0;
      lat_cnt_q   <= '0;
      beat_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      perf_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            line_idx_q <= acc_idx;
            err_q      <= acc_err;
            lat_cnt_q  <= LAT_W'(LATENCY - 1);
            perf_q     <= perf_q + 32'd1;
            if (LATENCY == 1) begin
              state_q     <= BURST;
              beat_cnt_q  <= '0;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= rd_data;
              rsp_err_q   <= rd_err;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          lat_cnt_q <= lat_cnt_q - LAT_W'(1);
          if (lat_cnt_q == LAT_W'(1)) begin
            state_q     <= BURST;
            beat_cnt_q  <= '0;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= rd_data;
            rsp_err_q   <= rd_err;
          end
        end
        BURST: begin
          if (beat_cnt_q == LAST_BEAT) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
          end else begin
            beat_cnt_q <= rd_beat;
            rsp_data_q <= rd_data;
            rsp_err_q  <= rd_err;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_rsp_valid_o  = rsp_valid_q;
  assign mem_rsp_data_o   = rsp_data_q;
  assign mem_rsp_err_o    = rsp_err_q;
  assign busy_o           = (state_q != IDLE);
  assign perf_req_count_o = perf_q;

endmodule

// File: tb/tb_icache_fill_responder.sv
// Scoreboard bench for icache_fill_responder: predicts acceptance, beat timing and data from its own memory model.
module tb_icache_fill_responder;
  localparam int          MEM_WORDS = 4096;
  localparam int          LINE_SIZE = 32;
  localparam int          LATENCY   = 4;
  localparam int          WPL       = LINE_SIZE / 4;
  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        mem_req_valid_i = 1'b0;
  logic [31:0] mem_req_addr_i = '0;
  logic        mem_req_ready_o;
  logic        mem_rsp_valid_o;
  logic [31:0] mem_rsp_data_o;
  logic        mem_rsp_err_o;
  logic        load_we_i = 1'b0;
  logic [11:0] load_addr_i = '0;
  logic [31:0] load_data_i = '0;
  logic        busy_o;
  logic [31:0] perf_req_count_o;

  always #5 clk_i = ~clk_i;

  icache_fill_responder #(
    .MEM_WORDS(MEM_WORDS), .LINE_SIZE(LINE_SIZE), .ADDR_WIDTH(32),
    .BASE_ADDR(BASE_ADDR), .LATENCY(LATENCY)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .mem_req_valid_i(mem_req_valid_i), .mem_req_addr_i(mem_req_addr_i),
    .mem_req_ready_o(mem_req_ready_o), .mem_rsp_valid_o(mem_rsp_valid_o),
    .mem_rsp_data_o(mem_rsp_data_o), .mem_rsp_err_o(mem_rsp_err_o),
    .load_we_i(load_we_i), .load_addr_i(load_addr_i), .load_data_i(load_data_i),
    .busy_o(busy_o), .perf_req_count_o(perf_req_count_o)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] mem_m [MEM_WORDS];
  int cyc = 0, free_cyc = 0, acc_cnt = 0;
  int n_checks = 0, n_errs = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Acceptance model: predicts which edges accept a request and queues the resulting beats.
  always @(posedge clk_i) begin
    longint base_l, lim_l;
    logic   err;
    beat_t  b;
    cyc++;
    if (rst_ni && mem_req_valid_i && !load_we_i && cyc >= free_cyc) begin
      base_l = longint'(mem_req_addr_i) & ~longint'(LINE_SIZE - 1);
      lim_l  = longint'(BASE_ADDR) + 4 * MEM_WORDS;
      err    = (base_l < longint'(BASE_ADDR)) || (base_l + LINE_SIZE > lim_l);
      for (int k = 0; k < WPL; k++) begin
        b.err  = err;
        b.data = err ? 32'd0 : mem_m[int'((base_l - longint'(BASE_ADDR)) / 4) + k];
        b.cyc  = cyc + LATENCY - 1 + k;
        exp_q.push_back(b);
      end
      free_cyc = cyc + LATENCY + WPL;
      acc_cnt++;
    end
  end

  // Output monitor, sampled mid-cycle.
  always @(negedge clk_i) begin
    logic  ev, idle;
    beat_t b;
    #1;
    if (rst_ni) begin
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        b = exp_q.pop_front();
        check("beat_cyc", 32'(b.cyc), 32'(cyc));
      end
      ev   = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      idle = (cyc + 1 >= free_cyc);
      check("rsp_valid", 32'(mem_rsp_valid_o), 32'(ev));
      if (ev) begin
        b = exp_q.pop_front();
        check("rsp_data", mem_rsp_data_o, b.data);
        check("rsp_err", 32'(mem_rsp_err_o), 32'(b.err));
      end else begin
        check("idle_data", mem_rsp_data_o, 32'd0);
        check("idle_err", 32'(mem_rsp_err_o), 32'd0);
      end
      check("ready", 32'(mem_req_ready_o), 32'(idle && !load_we_i));
      check("busy", 32'(busy_o), 32'(!idle));
      check("perf", perf_req_count_o, 32'(acc_cnt));
    end
  end

  task automatic load_word(input int a, input logic [31:0] d);
    @(negedge clk_i);
    load_we_i   = 1'b1;
    load_addr_i = 12'(a);
    load_data_i = d;
    mem_m[a]    = d;
    @(negedge clk_i);
    load_we_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      #2;
      if (exp_q.size() == 0) break;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic req_line(input logic [31:0] a);
    @(negedge clk_i);
    mem_req_valid_i = 1'b1;
    mem_req_addr_i  = a;
    @(negedge clk_i);
    mem_req_valid_i = 1'b0;
    drain();
  endtask

  initial begin
    int start;
    #2 rst_ni = 1'b0;
    #1;
    check("rst_ready", 32'(mem_req_ready_o), 32'd0);
    check("rst_valid", 32'(mem_rsp_valid_o), 32'd0);
    check("rst_data", mem_rsp_data_o, 32'd0);
    check("rst_err", 32'(mem_rsp_err_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_perf", perf_req_count_o, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("ready_after_rst", 32'(mem_req_ready_o), 32'd1);

    for (int i = 0; i < 16; i++)
      load_word(i, (i < 8) ? 32'h1000 + 32'(i) : 32'h2000 + 32'(i - 8));

    req_line(32'h0000_0008);
    check("perf_first", perf_req_count_o, 32'd1);
    req_line(32'h0000_0010);
    req_line(32'h0000_4000);

    // Held request: exactly two acceptances, the second right after the first burst.
    start = acc_cnt;
    @(negedge clk_i);
    mem_req_valid_i = 1'b1;
    mem_req_addr_i  = 32'h0000_0020;
    @(negedge clk_i);
    mem_req_addr_i = 32'h0000_0000;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (acc_cnt >= start + 2) break;
    end
    mem_req_valid_i = 1'b0;
    check("perf_hold", perf_req_count_o, 32'(start + 2));
    drain();

    // Preload write collides with a request in IDLE.
    start = acc_cnt;
    @(negedge clk_i);
    load_we_i = 1'b1; load_addr_i = 12'd2; load_data_i = 32'hBEEF_0002; mem_m[2] = 32'hBEEF_0002;
    mem_req_valid_i = 1'b1; mem_req_addr_i = 32'h0000_0004;
    #1;
    check("ready_on_load", 32'(mem_req_ready_o), 32'd0);
    @(negedge clk_i);
    load_we_i = 1'b0;
    check("perf_load_block", perf_req_count_o, 32'(start));
    @(negedge clk_i);
    mem_req_valid_i = 1'b0;
    drain();

    // Reset in the middle of the burst, during beat 3.
    @(negedge clk_i);
    mem_req_valid_i = 1'b1;
    mem_req_addr_i  = 32'h0000_0000;
    @(negedge clk_i);
    mem_req_valid_i = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      #2;
      if (exp_q.size() <= WPL - 3) break;
    end
    @(posedge clk_i);
    #1;
    check("pre_rst_valid", 32'(mem_rsp_valid_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_valid", 32'(mem_rsp_valid_o), 32'd0);
    check("mid_rst_data", mem_rsp_data_o, 32'd0);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_perf", perf_req_count_o, 32'd0);
    exp_q.delete();
    free_cyc = 0;
    acc_cnt  = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("post_rst_ready", 32'(mem_req_ready_o), 32'd1);
    check("post_rst_busy", 32'(busy_o), 32'd0);
    check("post_rst_perf", perf_req_count_o, 32'd0);
    req_line(32'h0000_0008);
    req_line(32'h0000_003C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
